// File: rtl/jt10_adpcmb_fetch_pkg.sv
// Shared types for the ADPCM-B nibble fetcher: fill target and nibble select.
package jt10_adpcmb_fetch_pkg;

  localparam int DEF_AW = 24;

  typedef enum logic {
    TGT_CUR = 1'b0,
    TGT_NXT = 1'b1
  } fill_tgt_e;

  function automatic logic [3:0] pick_nib(input logic [7:0] b, input logic sel);
    return sel ? b[3:0] : b[7:4];
  endfunction

endpackage

// File: rtl/jt10_adpcmb_fetch_if.sv
// ROM byte bus between the ADPCM-B fetcher (master) and the sample ROM (slave).
interface jt10_adpcmb_fetch_if
  import jt10_adpcmb_fetch_pkg::*;
#(
  parameter int AW = DEF_AW
);
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [7:0]    rom_data;
  logic          rom_ok;

  modport master (output rom_addr, rom_cs, input rom_data, rom_ok);
  modport slave  (input rom_addr, rom_cs, output rom_data, rom_ok);
endinterface

// File: rtl/jt10_adpcmb_romreq.sv
// ROM request handshake: latch address, hold cs through SETUP/WAIT, strobe capture on ok.
module jt10_adpcmb_romreq
  import jt10_adpcmb_fetch_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          on,
  input  logic          req,
  input  logic [AW-1:0] req_addr,
  output logic          rdy,
  output logic          cap,
  output logic [AW-1:0] cap_tag,
  output logic [7:0]    cap_byte,
  jt10_adpcmb_fetch_if.master rom
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        st, st_nx;
  logic [AW-1:0] addr_q;
  logic          cs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      addr_q <= '0;
    end else begin
      st <= st_nx;
      if (st == IDLE && on && req) addr_q <= req_addr;
    end
  end

  // SETUP never samples rom_ok: it may still be high from the previous address.
  always_comb begin
    st_nx = st;
    cs    = 1'b0;
    cap   = 1'b0;
    case (st)
      IDLE:  if (on && req) st_nx = SETUP;
      SETUP: begin
        cs    = 1'b1;
        st_nx = WAIT;
      end
      WAIT: begin
        cs = 1'b1;
        if (rom.rom_ok) begin
          cap   = 1'b1;
          st_nx = IDLE;
        end
      end
      default: st_nx = IDLE;
    endcase
    if (!on) begin
      st_nx = IDLE;
      cs    = 1'b0;
      cap   = 1'b0;
    end
  end

  assign rdy          = (st == IDLE);
  assign cap_tag      = addr_q;
  assign cap_byte     = rom.rom_data;
  assign rom.rom_addr = addr_q;
  assign rom.rom_cs   = cs;

endmodule

// File: rtl/jt10_adpcmb_fetch.sv
// ADPCM-B nibble fetcher: two-byte CUR/NXT buffer, prefetches ahead of the sample counter.
module jt10_adpcmb_fetch
  import jt10_adpcmb_fetch_pkg::*;
#(
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          on,
  input  logic [AW-1:0] addr,
  input  logic          nibble_sel,
  input  logic          adv,
  output logic [3:0]    data,
  output logic          miss,
  jt10_adpcmb_fetch_if.master rom
);

  typedef struct packed {
    logic [AW-1:0] tag;
    logic [7:0]    dat;
    logic          vld;
  } buf_t;

  buf_t          cur, nxt, fill;
  fill_tgt_e     tgt, req_tgt;
  logic          hit_cur, hit_nxt, no_hit, cons, promote;
  logic          req, req_rdy, cap, fill_ok;
  logic [AW-1:0] req_addr, cap_tag, addr_inc, cur_inc, nxt_inc;
  logic [7:0]    cap_byte;

  assign hit_cur  = cur.vld && (cur.tag == addr);
  assign hit_nxt  = nxt.vld && (nxt.tag == addr);
  assign no_hit   = !hit_cur && !hit_nxt;
  assign cons     = cen && on && adv;
  assign promote  = cons && !hit_cur && hit_nxt;
  assign addr_inc = addr + AW'(1);
  assign cur_inc  = cur.tag + AW'(1);
  assign nxt_inc  = nxt.tag + AW'(1);

  // A byte already sitting in NXT will be promoted, so it does not count as a CUR miss.
  always_comb begin
    req      = 1'b0;
    req_addr = addr;
    req_tgt  = TGT_CUR;
    if (on) begin
      if (no_hit) begin
        req      = 1'b1;
        req_addr = addr;
        req_tgt  = TGT_CUR;
      end else if (!nxt.vld) begin
        req      = 1'b1;
        req_addr = cur_inc;
        req_tgt  = TGT_NXT;
      end
    end
  end

  jt10_adpcmb_romreq #(.AW(AW)) u_romreq (
    .clk      (clk),
    .rst_n    (rst_n),
    .on       (on),
    .req      (req),
    .req_addr (req_addr),
    .rdy      (req_rdy),
    .cap      (cap),
    .cap_tag  (cap_tag),
    .cap_byte (cap_byte),
    .rom      (rom)
  );

  // Bytes that no longer sit at addr or addr+1 belong to an abandoned stream position.
  assign fill_ok = cap && ((cap_tag == addr) || (cap_tag == addr_inc));
  assign fill    = '{tag: cap_tag, dat: cap_byte, vld: 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
      nxt <= '0;
      tgt <= TGT_CUR;
    end else if (!on) begin
      cur.vld <= 1'b0;
      nxt.vld <= 1'b0;
    end else begin
      if (req && req_rdy) tgt <= req_tgt;
      if (cons && !hit_cur) begin
        if (hit_nxt) begin
          cur     <= nxt;
          nxt.vld <= 1'b0;
        end else begin
          cur.vld <= 1'b0;
          nxt.vld <= 1'b0;
        end
      end
      // Promotion owns CUR this cycle; a fill can only land behind the new CUR.
      if (fill_ok) begin
        if (promote) begin
          if (cap_tag == nxt_inc) nxt <= fill;
        end else if (tgt == TGT_CUR) begin
          cur <= fill;
        end else begin
          nxt <= fill;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= 4'd0;
      miss <= 1'b0;
    end else if (cen) begin
      miss <= cons && no_hit;
      if (!on)          data <= 4'd0;
      else if (adv) begin
        if (hit_cur)      data <= pick_nib(cur.dat, nibble_sel);
        else if (hit_nxt) data <= pick_nib(nxt.dat, nibble_sel);
        else              data <= 4'd0;
      end
    end
  end

endmodule

// File: doc/jt10_adpcmb_fetch.md
JT10_ADPCMB_FETCH -- requirements
Module: jt10_adpcmb_fetch

Interface
REQ-001 Parameter: AW, 24, ROM byte-address width; equals the width of the counter address.
REQ-002 clk  in  1  CPU clock; the only clock.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cen  in  1  clock enable; clk & cen = 55 kHz sample strobe, same strobe the ADPCM-B counter uses.
REQ-005 on  in  1  channel enable.
REQ-006 addr  in  AW  byte address from counter.
REQ-007 nibble_sel  in  1  0 = high nibble, 1 = low nibble.
REQ-008 adv  in  1  counter advance; a nibble is consumed on cen & adv.
REQ-009 rom_addr  out  AW  external ROM byte address.
REQ-010 rom_cs  out  1  ROM request, level.
REQ-011 rom_data  in  8  ROM byte.
REQ-012 rom_ok  in  1  ROM data valid for the current rom_addr, level.
REQ-013 data  out  4  delivered ADPCM nibble.
REQ-014 miss  out  1  one-cen pulse: the requested byte was not buffered.

Function
REQ-015 Two byte buffers SHALL be held: CUR (tag, byte, valid) and NXT (tag, byte, valid).
REQ-016 On cen & on & adv with addr == CUR.tag & CUR.valid: data <= nibble_sel ? byte[3:0] : byte[7:4].
REQ-017 On cen & on & adv with addr == NXT.tag & NXT.valid: NXT is promoted to CUR, NXT is invalidated, and data is taken from the promoted byte in the same cycle.
REQ-018 On cen & on & adv with no hit: data <= 0, miss = 1 for that cen period, both buffers invalidated.
REQ-019 The fetch FSM states SHALL be IDLE, SETUP, WAIT.
REQ-020 IDLE->SETUP when on and either CUR misses addr (fetch addr) or NXT is invalid (fetch CUR.tag+1, modulo 2^AW); CUR has priority.
REQ-021 SETUP: rom_addr is loaded, rom_cs = 1, rom_ok is ignored for this one clk (stale ok); next state WAIT.
REQ-022 WAIT: rom_cs = 1, rom_addr stable; on rom_ok, rom_data is captured into the target buffer with its tag, then IDLE; rom_cs drops for at least one clk.
REQ-023 A fetch completing in WAIT whose tag is no longer addr or addr+1 SHALL be discarded (addr jump, e.g. repeat to start).
REQ-024 A CUR fill and a promotion in the same clk: promotion wins; the fill goes to NXT if its tag equals the new CUR.tag+1, else it is dropped.
REQ-025 Tag increment SHALL wrap 2^AW-1 -> 0.
REQ-026 on = 0: both buffers invalid, FSM forced to IDLE (in-flight fetch abandoned), rom_cs = 0, data <= 0 on cen; miss stays 0.
REQ-027 The fetcher SHALL operate every clk (not gated by cen); only data/miss and buffer consumption are cen-qualified.
REQ-028 data and miss are registered; the new value is visible one clk after the qualifying cen.

Reset
REQ-029 Reset values: data = 0, miss = 0, rom_cs = 0, rom_addr = 0, both buffers invalid with tags and bytes 0, FSM = IDLE.
REQ-030 Reset asserted mid-fetch SHALL drop rom_cs immediately (asynchronously).

Structure
REQ-031 FSM state encoding SHALL be local parameters; no shared package entries are required.
REQ-032 One sub-module is natural: jt10_adpcmb_romreq (SETUP/WAIT handshake, rom_addr/rom_cs, capture strobe).

Verification
REQ-033 ROM with latency 3 clk, 55 kHz cen, addr 0x000100 nibble_sel 0 then 1 after prefetch -> data 0xA, 0x5 for byte 0xA5; miss never set.
REQ-034 Cold start with on rising, adv on first cen -> miss = 1, data = 0; the following cen returns the correct nibble.
REQ-035 addr jumps 0x0001FF -> 0x000100 (repeat) while a fetch of 0x000200 is in WAIT -> fetch discarded, 0x000100 fetched, no stale nibble delivered.
REQ-036 rom_ok held high from the previous access -> the first clk after address load ignored; captured byte matches the new address.
REQ-037 on dropped in WAIT, then reset pulse mid-fetch -> rom_cs = 0 at once, buffers invalid, data = 0.
REQ-038 addr = 0xFFFFFF consumed -> NXT fetch of 0x000000 issued.
